// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RESP = 3'd4
    } state_t;

    // Memory bus transfer size encodings
    localparam logic [1:0] SZ_IDLE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // RV32 load/store funct3 values (stores use the first three)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Response fault codes
    localparam logic [1:0] FLT_OK       = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_RANGE    = 2'b10;
    localparam logic [1:0] FLT_ILLEGAL  = 2'b11;

    // Number of bytes touched by a legal access with this funct3
    function automatic logic [32:0] access_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   access_bytes = 33'd1;
            2'b01:   access_bytes = 33'd2;
            default: access_bytes = 33'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of a raw bus word according to the load funct3.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: funct3 (load type), raw (bus word, bytes packed from bit 0), ext (extended result).
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   ext = {24'd0, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit mastering the memory controller's tri-state bus.
// Latency: accept->resp_valid 1 edge on fault, 2 on store, 3 on load.
// Backpressure: req_ready low from accept until the response handshake; response held until resp_ready.
// Ports: req_* (request valid/ready from execute), resp_* (result valid/ready),
//        bus_addr/bus_data/bus_rw/bus_size (memory controller bus, bus_data driven only while writing).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] MEM_BASE = 32'h0000_0000,
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_fault,
    output logic [31:0] bus_addr,
    inout  wire  [31:0] bus_data,
    output logic        bus_rw,
    output logic [1:0]  bus_size
);

    state_t      state;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;
    logic [31:0] rd_ext;

    logic        illegal;
    logic        misalign;
    logic        out_of_range;
    logic [1:0]  req_fault;
    logic [1:0]  req_size;
    logic [32:0] end_addr;
    logic [32:0] limit;

    // Classification of the request currently presented; used only at accept.
    always_comb begin
        if (req_we)
            illegal = (req_funct3 > F3_W);
        else
            illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);

        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

        // 33-bit sum so an access near 2^32 cannot wrap back into range
        end_addr     = {1'b0, req_addr} + access_bytes(req_funct3);
        limit        = {1'b0, MEM_BASE} + 33'(MEM_SIZE);
        out_of_range = (req_addr < MEM_BASE) || (end_addr > limit);

        if (illegal)
            req_fault = FLT_ILLEGAL;
        else if (misalign)
            req_fault = FLT_MISALIGN;
        else if (out_of_range)
            req_fault = FLT_RANGE;
        else
            req_fault = FLT_OK;

        // funct3[1:0] 00/01/10 -> byte/half/word; 11 is always illegal
        req_size = req_funct3[1:0] + 2'd1;
    end

    load_extend u_load_extend (
        .funct3 (funct3_q),
        .raw    (bus_data),
        .ext    (rd_ext)
    );

    assign bus_data = (state == WR) ? wdata_q : 32'bz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_fault <= FLT_OK;
            bus_addr   <= 32'd0;
            bus_rw     <= 1'b0;
            bus_size   <= SZ_IDLE;
            wdata_q    <= 32'd0;
            funct3_q   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        wdata_q   <= req_wdata;
                        funct3_q  <= req_funct3;
                        if (req_fault != FLT_OK) begin
                            resp_fault <= req_fault;
                            resp_rdata <= 32'd0;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            bus_addr <= req_addr;
                            bus_size <= req_size;
                            bus_rw   <= req_we;
                            state    <= req_we ? WR : RD1;
                        end
                    end
                end
                WR: begin
                    // Controller commits the write on this edge
                    bus_rw     <= 1'b0;
                    bus_size   <= SZ_IDLE;
                    resp_fault <= FLT_OK;
                    resp_rdata <= 32'd0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RD1: begin
                    // Controller latches its read buffer here and drives it during RD2
                    state <= RD2;
                end
                RD2: begin
                    bus_size   <= SZ_IDLE;
                    resp_fault <= FLT_OK;
                    resp_rdata <= rd_ext;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    bus_size  <= SZ_IDLE;
                    bus_rw    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the shared memory controller and is the only master on its 32-bit tri-state bus.
- Accepts one load/store request at a time from the CPU execute stage over a valid/ready handshake.
- Drives the bus addr/data/rw/size signals with the controller's required timing, then sign- or zero-extends load data.
- Returns the result, or a fault, over a second valid/ready handshake.

Parameters:
- MEM_BASE, 32'h0000_0000, base address of the memory region the controller decodes.
- MEM_SIZE, 1024, size of that region in bytes; accesses outside [MEM_BASE, MEM_BASE+MEM_SIZE) fault.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3
- bus_addr  out  32  memory bus address
- bus_data  inout  32  memory bus data
- bus_rw  out  1  1 = write, 0 = read
- bus_size  out  2  00 idle, 01 byte, 10 half, 11 word

Behaviour:
- Reset: state IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, bus_addr=0, bus_rw=0, bus_size=00, bus_data released (Z). Reset is asynchronous, so an access in flight is abandoned. bus_size drops to 00 immediately, so no write commits.
- bus_data is driven only when the state is WR. In every other state it is Z.
- bus_size is 00 in every state except WR, RD1 and RD2.
- Accept: req_valid && req_ready on edge T0. Latch addr, wdata, we, funct3; req_ready goes low. Classify combinationally at accept; the first match wins:
  - illegal funct3 (load 011/110/111; store >= 011) -> 11
  - misaligned (half addr[0]!=0; word addr[1:0]!=0) -> 01
  - out of range (addr < MEM_BASE or addr+bytes > MEM_BASE+MEM_SIZE) -> 10
- Faulted request goes to RESP with no bus activity. resp_fault is set and resp_rdata=0.
- Size map: funct3[1:0] 00 -> 01 (byte), 01 -> 10 (half), 10 -> 11 (word).
- States: IDLE, WR, RD1, RD2, RESP.
- IDLE -> WR (store ok), RD1 (load ok), RESP (fault).
- WR, one cycle:
  - bus_rw=1, bus_size=size, bus_addr=addr, bus_data=wdata.
  - The controller writes at the next edge.
  - Next state RESP; resp_valid high one cycle after T0+1.
- RD1: bus_rw=0, size and addr held. The controller captures its buffer at the end of RD1. Next state RD2.
- RD2:
  - Inputs are held stable.
  - The controller drives bus_data with bytes packed from bit 0.
  - Sample at the end of RD2 and extend: LB sign-extends [7:0], LBU zero-extends [7:0], LH/LHU the same on [15:0], LW passes through.
  - Next state RESP.
- Load latency: accept edge to resp_valid is 3 edges. Store latency is 2 edges. Fault latency is 1 edge.
- RESP: resp_valid=1 and outputs held stable until resp_ready. On the handshake edge go to IDLE; resp_valid drops and req_ready rises.
  - No new request is accepted in the same edge (single outstanding, no bypass).
  - Back-to-back throughput is therefore 4 cycles per load.
- req_valid while req_ready=0 is ignored; the producer holds it.
- resp_ready high with no resp_valid has no effect.
- addr + bytes must not overflow 32 bits. The range check uses a 33-bit sum.

Decomposition:
- Package lsu_pkg holds:
  - state enum (IDLE, WR, RD1, RD2, RESP)
  - bus size encodings (SZ_IDLE/SZ_BYTE/SZ_HALF/SZ_WORD)
  - funct3 constants (F3_B/F3_H/F3_W/F3_BU/F3_HU)
  - fault codes (FLT_OK/FLT_MISALIGN/FLT_RANGE/FLT_ILLEGAL)
- One combinational sub-module, load_extend: inputs funct3 and the raw 32-bit bus word, output the 32-bit extended result. It is unit-testable alone.

Test Plan:
- Store then load: SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_rdata 0xDEADBEEF, fault 00; load resp_valid exactly 3 edges after accept.
- Load extension: SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80; LBU -> 0x00000080. SH 0x8001 @0x22, then LH -> 0xFFFF8001; LHU -> 0x00008001.
- Faults: LW @0x2 -> fault 01; LH @0x3FF -> 01; LW @0x400 -> 10; SB @0x3FF -> ok; funct3 011 load -> 11. For each, bus_size stays 00 throughout and resp_valid arrives 1 edge after accept.
- Backpressure: resp_ready held low 5 cycles after an LW -> resp_valid and resp_rdata stable and req_ready=0; a second req_valid during the hold is not accepted.
- Reset mid-op: rst_n asserted during WR of SW 0x12345678 @0x40 -> bus_size=00 and bus_data=Z immediately; after release, LW @0x40 returns the old value 0.
- Bus hygiene: across random traffic, bus_data is never driven by the unit while bus_rw=0, and bus_size=00 in IDLE and RESP.
